// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle barrel-free shifter. Accepts an operand over a
// valid/ready handshake, shifts by up to STEP bits per clock, and returns
// the result plus the last bit shifted out over a second handshake.
module shifter_seq #(
   parameter int WIDTH = 16,
   parameter int STEP  = 1,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] shift_in,
   input  logic [1:0]       shift_op,
   input  logic [AMT_W-1:0] shift_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] shift_out,
   output logic             carry_out
);

   // The remaining distance never exceeds WIDTH-1, so capping the per-cycle
   // step at WIDTH-1 is equivalent to STEP and keeps it inside AMT_W bits.
   localparam int              STEP_CAP = (STEP >= WIDTH) ? (WIDTH - 1) : STEP;
   localparam logic [AMT_W-1:0] STEP_A  = AMT_W'(STEP_CAP);

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_LSL  = 2'b01;
   localparam logic [1:0] OP_LSR  = 2'b10;
   localparam logic [1:0] OP_ASR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   state_t             state_r, state_nxt_s;
   logic [WIDTH-1:0]   data_r, data_nxt_s;
   logic [1:0]         op_r, op_nxt_s;
   logic [AMT_W-1:0]   rem_r, rem_nxt_s;
   logic               carry_r, carry_nxt_s;
   logic [AMT_W-1:0]   step_s;
   logic [WIDTH:0]     lsl_ext_s;
   logic [WIDTH:0]     rsh_ext_s;
   logic [WIDTH:0]     asr_ext_s;

   // Per-cycle shift distance: min(remaining, STEP).
   always_comb begin
      step_s = rem_r;
      if (rem_r > STEP_A) begin
         step_s = STEP_A;
      end else begin
         step_s = rem_r;
      end
   end

   // One-step shifters, widened by one bit so the extra bit captures the carry.
   always_comb begin
      lsl_ext_s = {1'b0, data_r} << step_s;
      rsh_ext_s = {data_r, 1'b0} >> step_s;
      asr_ext_s = $unsigned($signed({data_r, 1'b0}) >>> step_s);
   end

   // Next-state and datapath update; flush dominates every other input.
   always_comb begin
      state_nxt_s = state_r;
      data_nxt_s  = data_r;
      op_nxt_s    = op_r;
      rem_nxt_s   = rem_r;
      carry_nxt_s = carry_r;
      if (flush) begin
         state_nxt_s = ST_IDLE;
         rem_nxt_s   = {AMT_W{1'b0}};
         carry_nxt_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  data_nxt_s  = shift_in;
                  op_nxt_s    = shift_op;
                  carry_nxt_s = 1'b0;
                  if ((shift_op == OP_NONE) || (shift_amt == {AMT_W{1'b0}})) begin
                     rem_nxt_s   = {AMT_W{1'b0}};
                     state_nxt_s = ST_DONE;
                  end else begin
                     rem_nxt_s   = shift_amt;
                     state_nxt_s = ST_SHIFT;
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_SHIFT: begin
               case (op_r)
                  OP_LSL: begin
                     data_nxt_s  = lsl_ext_s[WIDTH-1:0];
                     carry_nxt_s = lsl_ext_s[WIDTH];
                  end
                  OP_LSR: begin
                     data_nxt_s  = rsh_ext_s[WIDTH:1];
                     carry_nxt_s = rsh_ext_s[0];
                  end
                  OP_ASR: begin
                     data_nxt_s  = asr_ext_s[WIDTH:1];
                     carry_nxt_s = asr_ext_s[0];
                  end
                  default: begin
                     data_nxt_s  = data_r;
                     carry_nxt_s = carry_r;
                  end
               endcase
               rem_nxt_s = rem_r - step_s;
               if (rem_r == step_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_SHIFT;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_DONE;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               rem_nxt_s   = {AMT_W{1'b0}};
               carry_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath registers: operand/result, latched op, remaining distance, carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r  <= {WIDTH{1'b0}};
         op_r    <= 2'b00;
         rem_r   <= {AMT_W{1'b0}};
         carry_r <= 1'b0;
      end else begin
         data_r  <= data_nxt_s;
         op_r    <= op_nxt_s;
         rem_r   <= rem_nxt_s;
         carry_r <= carry_nxt_s;
      end
   end

   assign in_ready  = (state_r == ST_IDLE);
   assign out_valid = (state_r == ST_DONE);
   assign shift_out = data_r;
   assign carry_out = carry_r;

endmodule

// File: tb/tb_shifter_seq.sv
// tb_shifter_seq: directed vectors against two instances, STEP=1 and STEP=4.
module tb_shifter_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [15:0] shift_in;
   logic [1:0]  shift_op;
   logic [3:0]  shift_amt;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, carry1;
   logic [15:0] out1;
   logic        in_valid4, in_ready4, out_valid4, out_ready4, carry4;
   logic [15:0] out4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   shifter_seq #(.WIDTH(16), .STEP(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .shift_in(shift_in), .shift_op(shift_op), .shift_amt(shift_amt),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .shift_out(out1), .carry_out(carry1)
   );

   shifter_seq #(.WIDTH(16), .STEP(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .shift_in(shift_in), .shift_op(shift_op), .shift_amt(shift_amt),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .shift_out(out4), .carry_out(carry4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic ov(input bit s4);
      return s4 ? out_valid4 : out_valid1;
   endfunction

   function automatic logic ir(input bit s4);
      return s4 ? in_ready4 : in_ready1;
   endfunction

   function automatic logic [15:0] so(input bit s4);
      return s4 ? out4 : out1;
   endfunction

   function automatic logic co(input bit s4);
      return s4 ? carry4 : carry1;
   endfunction

   // Present a request at the falling edge; returns 1ns after acceptance edge.
   task automatic start(input bit s4, input logic [15:0] d, input logic [1:0] op,
                        input logic [3:0] amt, input string tag);
      @(negedge clk);
      check({tag, "_in_ready"}, ir(s4), 1);
      shift_in  = d;
      shift_op  = op;
      shift_amt = amt;
      if (s4) in_valid4 = 1'b1;
      else    in_valid1 = 1'b1;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      in_valid4 = 1'b0;
      // Scramble inputs: they must only be sampled at acceptance.
      shift_in  = ~d;
      shift_op  = ~op;
      shift_amt = amt ^ 4'hF;
   endtask

   // Latency in cycles after acceptance edge, bounded.
   task automatic wait_done(input bit s4, output int cyc);
      cyc = 1;
      while (!ov(s4) && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic finish_txn(input bit s4, input string tag);
      @(negedge clk);
      if (s4) out_ready4 = 1'b1;
      else    out_ready1 = 1'b1;
      @(posedge clk);
      #1;
      out_ready1 = 1'b0;
      out_ready4 = 1'b0;
      check({tag, "_ov_after"}, ov(s4), 0);
      check({tag, "_ir_after"}, ir(s4), 1);
   endtask

   task automatic run_txn(input string tag, input bit s4, input logic [15:0] d,
                          input logic [1:0] op, input logic [3:0] amt,
                          input logic [15:0] exp_out, input logic exp_c, input int exp_lat);
      int cyc;
      start(s4, d, op, amt, tag);
      wait_done(s4, cyc);
      check({tag, "_lat"}, cyc, exp_lat);
      check({tag, "_out"}, so(s4), exp_out);
      check({tag, "_carry"}, co(s4), exp_c);
      finish_txn(s4, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int seen;
      rst_n = 1'b0; flush = 1'b0;
      shift_in = 16'h0000; shift_op = 2'b00; shift_amt = 4'd0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;

      // Reset values
      #2;
      check("rst_in_ready1", in_ready1, 1);
      check("rst_out_valid1", out_valid1, 0);
      check("rst_out1", out1, 16'h0000);
      check("rst_carry1", carry1, 0);
      check("rst_in_ready4", in_ready4, 1);
      check("rst_out_valid4", out_valid4, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Main function
      run_txn("lsl1",    1'b0, 16'h8001, 2'b01, 4'd1,  16'h0002, 1'b1, 2);
      run_txn("asr15_s1",1'b0, 16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0, 16);
      run_txn("asr15_s4",1'b1, 16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0, 5);
      run_txn("lsr4_s4", 1'b1, 16'h00F0, 2'b10, 4'd4,  16'h000F, 1'b0, 2);
      run_txn("none",    1'b0, 16'h1234, 2'b00, 4'd5,  16'h1234, 1'b0, 1);
      run_txn("amt0",    1'b1, 16'h1234, 2'b01, 4'd0,  16'h1234, 1'b0, 1);
      run_txn("lsr2",    1'b0, 16'h0003, 2'b10, 4'd2,  16'h0000, 1'b1, 3);
      run_txn("lsl5_s4", 1'b1, 16'h0801, 2'b01, 4'd5,  16'h0020, 1'b1, 3);
      run_txn("asr4_s4", 1'b1, 16'h8008, 2'b11, 4'd4,  16'hF800, 1'b1, 2);

      // Backpressure with a queued request
      start(1'b0, 16'h0001, 2'b01, 4'd3, "bp");
      wait_done(1'b0, cyc);
      check("bp_lat", cyc, 4);
      check("bp_out", out1, 16'h0008);
      @(negedge clk);
      shift_in = 16'h0100; shift_op = 2'b10; shift_amt = 4'd8;
      in_valid1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_ov", out_valid1, 1);
         check("bp_hold_ir", in_ready1, 0);
         check("bp_hold_out", out1, 16'h0008);
         check("bp_hold_carry", carry1, 0);
      end
      @(negedge clk);
      out_ready1 = 1'b1;
      @(posedge clk);
      #1;
      out_ready1 = 1'b0;
      check("bp_rel_ov", out_valid1, 0);
      check("bp_rel_ir", in_ready1, 1);
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      check("bp_q_accept", in_ready1, 0);
      wait_done(1'b0, cyc);
      check("bp_q_lat", cyc, 9);
      check("bp_q_out", out1, 16'h0001);
      check("bp_q_carry", carry1, 0);
      finish_txn(1'b0, "bp_q");

      // Asynchronous reset during the third SHIFT cycle of ASR by 10
      start(1'b0, 16'h8000, 2'b11, 4'd10, "rst");
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("rst_mid_out", out1, 16'hE000);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ir", in_ready1, 1);
      check("rst_mid_ov", out_valid1, 0);
      check("rst_mid_out0", out1, 16'h0000);
      check("rst_mid_carry", carry1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_txn("post_rst", 1'b0, 16'h8000, 2'b10, 4'd15, 16'h0001, 1'b0, 16);

      // Flush mid-SHIFT
      start(1'b0, 16'h8001, 2'b11, 4'd8, "fl");
      @(posedge clk);
      #1;
      check("fl_pre_carry", carry1, 1);
      check("fl_pre_out", out1, 16'hC000);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("fl_ir", in_ready1, 1);
      check("fl_ov", out_valid1, 0);
      check("fl_carry", carry1, 0);
      check("fl_data_kept", out1, 16'hC000);
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (out_valid1) seen = 1;
      end
      check("fl_no_valid", seen, 0);

      // Flush together with in_valid in IDLE: no acceptance
      @(negedge clk);
      flush = 1'b1;
      in_valid1 = 1'b1;
      shift_in = 16'h5555; shift_op = 2'b00; shift_amt = 4'd0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid1 = 1'b0;
      check("fl_iv_ov", out_valid1, 0);
      check("fl_iv_ir", in_ready1, 1);
      check("fl_iv_out", out1, 16'hC000);
      run_txn("post_fl", 1'b0, 16'h0001, 2'b01, 4'd1, 16'h0002, 1'b0, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
